// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory: IDLE -> ACCESS -> RESP per transfer.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every tie and drop the last-served pointer.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [2:0]  p0_func3,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [2:0]  p1_func3,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        win_id;
  logic        lat_we;
  logic [2:0]  lat_func3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        any_req;
  logic        grant1;
  logic        start;

  assign any_req = p0_req | p1_req;
  assign start   = (state == IDLE) && any_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign grant1 = p1_req & ~p0_req;
`else
  // last_served names the port granted most recently; the other port wins a tie
  logic last_served;

  assign grant1 = p1_req & (~p0_req | ~last_served);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_served <= 1'b1;
    else if (start)
      last_served <= grant1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_func3 <= 3'b000;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else if (start) begin
      win_id    <= grant1;
      lat_we    <= grant1 ? p1_we    : p0_we;
      lat_func3 <= grant1 ? p1_func3 : p0_func3;
      lat_addr  <= grant1 ? p1_addr  : p0_addr;
      lat_wdata <= grant1 ? p1_wdata : p0_wdata;
    end
  end

  // Load data is captured on the edge that closes ACCESS; stores leave rdata alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rdata <= 32'h0;
      p1_rdata <= 32'h0;
    end else if (state == ACCESS && !lat_we) begin
      if (win_id)
        p1_rdata <= mem_rdata;
      else
        p0_rdata <= mem_rdata;
    end
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    busy      = (state != IDLE);
    if (state == ACCESS) begin
      mem_read  = ~lat_we;
      mem_write = lat_we;
    end
    if (state == RESP) begin
      p0_ack = ~win_id;
      p1_ack = win_id;
    end
  end

  assign mem_addr  = lat_addr;
  assign mem_func3 = lat_func3;
  assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transfers plus hand-written
// sequences for tie-breaking, reset mid-store and input changes during a transfer.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [2:0]  p0_func3, p1_func3;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ack, p1_ack;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_func3;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] exp_p0_rdata;
    logic [31:0] exp_p1_rdata;
  } vec_t;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_func3(p0_func3), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_func3(p1_func3), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_func3(mem_func3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Strobe exclusivity and single-ack are watched on every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      check_output("strobe_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
      check_output("ack_exclusive", {31'b0, p0_ack & p1_ack}, 32'h0);
    end
  end

  // Called at an IDLE negedge; returns at the following IDLE negedge
  task automatic apply_stimulus(input vec_t v, input string name);
    mem_rdata = v.mem_rdata;
    if (v.port) begin
      p1_req = 1'b1; p1_we = v.we; p1_func3 = v.func3; p1_addr = v.addr; p1_wdata = v.wdata;
    end else begin
      p0_req = 1'b1; p0_we = v.we; p0_func3 = v.func3; p0_addr = v.addr; p0_wdata = v.wdata;
    end
    @(negedge clk);
    check_output({name, " mem_read"}, {31'b0, mem_read}, {31'b0, !v.we});
    check_output({name, " mem_write"}, {31'b0, mem_write}, {31'b0, v.we});
    check_output({name, " mem_addr"}, mem_addr, v.addr);
    check_output({name, " mem_func3"}, {29'b0, mem_func3}, {29'b0, v.func3});
    check_output({name, " mem_wdata"}, mem_wdata, v.wdata);
    check_output({name, " busy"}, {31'b0, busy}, 32'h1);
    @(negedge clk);
    check_output({name, " p0_ack"}, {31'b0, p0_ack}, {31'b0, !v.port});
    check_output({name, " p1_ack"}, {31'b0, p1_ack}, {31'b0, v.port});
    check_output({name, " strobes_in_resp"}, {30'b0, mem_read, mem_write}, 32'h0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    check_output({name, " acks_after"}, {30'b0, p0_ack, p1_ack}, 32'h0);
    check_output({name, " busy_after"}, {31'b0, busy}, 32'h0);
    check_output({name, " p0_rdata"}, p0_rdata, v.exp_p0_rdata);
    check_output({name, " p1_rdata"}, p1_rdata, v.exp_p1_rdata);
  endtask

  initial begin
    vec_t vecs[5];
    int   waited;
    logic exp_port;
    logic [31:0] exp_p1_final;

    vecs[0] = '{1'b0, 1'b0, 3'b010, 32'h10, 32'h0,   32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 3'b000, 32'h20, 32'hAB,  32'h12345678, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 3'b100, 32'h24, 32'h0,   32'h000000FF, 32'hDEADBEEF, 32'hFF};
    vecs[3] = '{1'b0, 1'b1, 3'b001, 32'h30, 32'hCAFE, 32'h87654321, 32'hDEADBEEF, 32'hFF};
    vecs[4] = '{1'b0, 1'b0, 3'b101, 32'h3,  32'h0,   32'h0000BEEF, 32'h0000BEEF, 32'hFF};

    rst = 1'b1;
    p0_req = 1'b0; p0_we = 1'b0; p0_func3 = 3'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_func3 = 3'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_output("reset busy", {31'b0, busy}, 32'h0);
    check_output("reset strobes", {30'b0, mem_read, mem_write}, 32'h0);
    check_output("reset acks", {30'b0, p0_ack, p1_ack}, 32'h0);
    check_output("reset p0_rdata", p0_rdata, 32'h0);
    check_output("reset p1_rdata", p1_rdata, 32'h0);
    check_output("reset mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a p0 store: strobe drops at once, no ack, pointer back to port 1
    p0_req = 1'b1; p0_we = 1'b1; p0_func3 = 3'b010; p0_addr = 32'h60; p0_wdata = 32'h55;
    @(negedge clk);
    check_output("midrst store_active", {31'b0, mem_write}, 32'h1);
    rst = 1'b1;
    #1;
    check_output("midrst mem_write", {31'b0, mem_write}, 32'h0);
    check_output("midrst busy", {31'b0, busy}, 32'h0);
    check_output("midrst acks", {30'b0, p0_ack, p1_ack}, 32'h0);
    check_output("midrst mem_addr", mem_addr, 32'h0);
    check_output("midrst p0_rdata", p0_rdata, 32'h0);
    p0_req = 1'b0;
    @(negedge clk);
    check_output("midrst acks_later", {30'b0, p0_ack, p1_ack}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check_output("midrst idle", {31'b0, busy}, 32'h0);

    // Both ports requesting continuously
    mem_rdata = 32'h77777777;
    p0_req = 1'b1; p0_we = 1'b0; p0_func3 = 3'b010; p0_addr = 32'h40;
    p1_req = 1'b1; p1_we = 1'b0; p1_func3 = 3'b010; p1_addr = 32'h44;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!(p0_ack || p1_ack) && waited < 6);
      check_output($sformatf("tie ack%0d seen", g), {31'b0, p0_ack | p1_ack}, 32'h1);
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_port = 1'b0;
`else
      exp_port = (g % 2 == 1);
`endif
      check_output($sformatf("tie grant%0d", g), {31'b0, p1_ack}, {31'b0, exp_port});
      check_output($sformatf("tie spacing%0d", g), waited, (g == 0) ? 32'd2 : 32'd3);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_p1_final = 32'h0;
`else
    exp_p1_final = 32'h77777777;
`endif
    check_output("tie p1_rdata", p1_rdata, exp_p1_final);

    // Requester inputs change while the transfer is in flight
    mem_rdata = 32'hA5A5A5A5;
    p0_req = 1'b1; p0_we = 1'b0; p0_func3 = 3'b010; p0_addr = 32'h50;
    @(negedge clk);
    p0_addr = 32'h99;
    p0_we = 1'b1;
    p1_req = 1'b1; p1_we = 1'b1;
    #1;
    check_output("inflight mem_addr", mem_addr, 32'h50);
    check_output("inflight strobes", {30'b0, mem_read, mem_write}, 32'h2);
    @(negedge clk);
    check_output("inflight acks", {30'b0, p0_ack, p1_ack}, 32'h2);
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    check_output("inflight p0_rdata", p0_rdata, 32'hA5A5A5A5);
    check_output("inflight p1_rdata", p1_rdata, exp_p1_final);
    check_output("inflight idle", {31'b0, busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: p0_req/p1_req  input  1  access request; held high by the requester until it sees its ack.
REQ-004 SHALL have ports: p0_we/p1_we  input  1  1 = store, 0 = load.
REQ-005 SHALL have ports: p0_func3/p1_func3  input  3  access size/sign code, passed to memory unchanged.
REQ-006 SHALL have ports: p0_addr/p1_addr  input  32  byte address.
REQ-007 SHALL have ports: p0_wdata/p1_wdata  input  32  store data.
REQ-008 SHALL have ports: p0_rdata/p1_rdata  output  32  registered load data.
REQ-009 SHALL have ports: p0_ack/p1_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports: mem_read, mem_write  output  1  data-memory read/write strobes.
REQ-011 SHALL have ports: mem_addr  output  32, mem_func3  output  3, mem_wdata  output  32  data-memory address, size code and write data.
REQ-012 SHALL have port: mem_rdata  input  32  combinational data-memory read data.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-015 IDLE: on any sampled reqs, SHALL latch the winner's we/func3/addr/wdata and winner id, then go to ACCESS; with no req, SHALL stay in IDLE.
REQ-016 Arbitration: single req wins; on simultaneous reqs, the port not served last SHALL win (round-robin).
REQ-017 The last-served pointer SHALL update on every IDLE->ACCESS transition.
REQ-018 ACCESS: mem_addr/func3/wdata SHALL be driven from the latched values; mem_write = latched we; mem_read = ~latched we.
REQ-019 ACCESS: SHALL last exactly one cycle; the store commits at its closing edge, where mem_rdata is also captured into the winner's rdata register, then go to RESP.
REQ-020 RESP: SHALL assert the winner's ack for exactly one cycle, ignore all reqs, then return to IDLE.
REQ-021 Latency: req sampled at edge E0 -> ack high between E1 and E2; next grant sampled no earlier than E3.
REQ-022 mem_read and mem_write SHALL never be high together, and both SHALL be 0 outside ACCESS.
REQ-023 p*_rdata SHALL hold its value until the next load to that port; a store SHALL NOT alter it.
REQ-024 func3 and addr SHALL pass through unchecked; alignment and legality are the requester's responsibility.
REQ-025 Request inputs changing during ACCESS/RESP SHALL NOT affect the in-flight access.
REQ-026 p0_ack and p1_ack SHALL never be high in the same cycle.

Reset
REQ-027 rst high SHALL immediately force: state IDLE, mem_read = mem_write = 0, both acks 0, busy 0, rdata registers 0, mem_addr/func3/wdata 0, last-served pointer = port 1 (port 0 wins the first tie).
REQ-028 Reset during ACCESS/RESP SHALL abort the access with no ack issued; a store not yet committed SHALL NOT commit.

Configuration
REQ-029 Macro MEM_ARB_FIXED_PRIO_EN defined: ties SHALL always grant port 0, and no last-served pointer SHALL be implemented.
REQ-030 Macro MEM_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-016/017 SHALL apply.

Verification
REQ-031 After reset, p0 load with addr=0x10, func3=010, mem_rdata=0xDEADBEEF -> mem_read high one cycle at 0x10; p0_ack next cycle; p0_rdata=0xDEADBEEF.
REQ-032 p1 store with addr=0x20, func3=000, wdata=0x000000AB -> mem_write high exactly one cycle with addr 0x20/func3 000/wdata 0xAB; p1_ack one cycle later; p1_rdata unchanged.
REQ-033 p0 and p1 held continuously requesting, round-robin build -> grant order p0,p1,p0,p1, one ack every 3 cycles; MEM_ARB_FIXED_PRIO_EN build -> p0 every time.
REQ-034 rst asserted mid-ACCESS of a store -> mem_write drops immediately, no ack, FSM IDLE; after release, a p0 access is granted first on a tie.
REQ-035 p0_addr changed during ACCESS -> mem_addr keeps the latched address; no simultaneous mem_read/mem_write or dual ack in any cycle (assertion).
